fifo_egress_arbiter: RTL and testbench
======================================

# fifo_egress_arbiter

Round-robin drain arbiter sharing one downstream valid/ready stream between NR_OF_FIFOS_P `fifo_register` egress ports. It grants one FIFO at a time and pops up to a programmable burst of words from it into a registered output stage. It then rotates priority. It sits between a bank of per-source FIFOs and a single consumer such as a DMA writer or packet serialiser.

## Interface
- NR_OF_FIFOS_P, 4, number of FIFOs arbitrated (≥2)
- DATA_WIDTH_P, 8, FIFO word width
- BURST_WIDTH_P, 4, width of burst-length config; max burst 2^BURST_WIDTH_P-1
- Clock/reset: one clock; reset is synchronous and active-low
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cr_burst_length  in  BURST_WIDTH_P  max words per grant; 0 treated as 1; sampled at grant
- fifo_egr_empty  in  NR_OF_FIFOS_P  per-FIFO empty flag
- fifo_egr_data  in  NR_OF_FIFOS_P*DATA_WIDTH_P  per-FIFO head word, FIFO i at bits [i*DATA_WIDTH_P +: DATA_WIDTH_P]; first-word fall-through, valid while empty low
- fifo_egr_enable  out  NR_OF_FIFOS_P  one-hot pop strobe to FIFOs
- mst_valid  out  1  output word valid
- mst_ready  in  1  consumer accepts word
- mst_data  out  DATA_WIDTH_P  output word
- mst_id  out  $clog2(NR_OF_FIFOS_P)  index of the source FIFO of mst_data
- sr_grant  out  NR_OF_FIFOS_P  one-hot current grant, 0 when idle

## Operation
- FSM states: IDLE, BURST.
- IDLE:
  - If any fifo_egr_empty bit is low, pick the first non-empty index searching from last_grant+1 upward, modulo NR_OF_FIFOS_P.
  - Register grant index g, set last_grant <= g, load words_left <= max(cr_burst_length,1), and go to BURST.
  - Otherwise stay in IDLE. No pops occur in IDLE.
- BURST, pop condition: pop = !fifo_egr_empty[g] && words_left != 0 && (!mst_valid || mst_ready).
- BURST, on pop:
  - fifo_egr_enable[g]=1 (combinational).
  - mst_data <= fifo_egr_data[g], mst_id <= g, mst_valid <= 1, words_left <= words_left-1.
- BURST, without pop: if mst_valid && mst_ready, then mst_valid <= 0.
- BURST exit, back to IDLE, on either condition:
  - a pop with words_left==1
  - fifo_egr_empty[g] high in BURST with no pop (early termination; the burst is shortened and no error is flagged)
- The output stage drains independently of the FSM. A held word (mst_valid && !mst_ready) stays stable, with mst_data and mst_id unchanged, until accepted.
- Only one fifo_egr_enable bit is ever high. It is never high while the corresponding fifo_egr_empty is high.
- fifo_egr_enable is forced to 0 whenever rst_n is low, even before the reset edge.
- sr_grant = one-hot(g) in BURST, 0 in IDLE.
- Arithmetic:
  - last_grant wraps from NR_OF_FIFOS_P-1 to 0.
  - words_left is BURST_WIDTH_P wide and never underflows because a pop requires words_left != 0.

## Timing
- Reset values (at the first clk edge with rst_n low):
  - state IDLE
  - last_grant NR_OF_FIFOS_P-1, so FIFO 0 has first priority
  - words_left 0
  - mst_valid 0, mst_data 0, mst_id 0
  - sr_grant 0, fifo_egr_enable 0
- Latency: fifo_egr_empty[i] falls in cycle 0 while IDLE → BURST at edge 1 → pop during cycle 1 → mst_valid at edge 2.
- Throughput: one word per cycle while mst_ready is held high and the granted FIFO stays non-empty.
- Each grant costs one IDLE arbitration cycle with no pop.
- Simultaneous accept and pop: both occur in the same cycle, and mst_valid stays 1 with the new word.
- FIFO empties mid-burst: fifo_egr_empty is sampled each cycle. The exit to IDLE takes effect at the next edge.
- Reset mid-burst: the held output word is discarded. Words already popped are lost; this is accepted.
- A config change during BURST has no effect until the next grant.

## Test plan
- Reset then idle: all FIFOs empty for 20 cycles → fifo_egr_enable=0, mst_valid=0, sr_grant=0 throughout.
- Single source: FIFO 2 holds 3 words A,B,C, burst=8, mst_ready=1 → mst_data A,B,C with mst_id=2 on consecutive cycles starting 2 cycles after empty falls; the burst then ends early and the FSM returns to IDLE.
- Round robin with burst limit: all 4 FIFOs hold 5 words, burst=2 → mst_id sequence 0,0,1,1,2,2,3,3,0,0,… with one bubble per grant; 20 words are delivered in total.
- Backpressure: FIFO 1 full, burst=4, mst_ready toggling 1,0,0,1,… → no word is lost or duplicated, mst_data is stable while stalled, and exactly 4 pops occur per grant.
- Burst length 0 is treated as 1: FIFOs 0 and 3 non-empty, cr_burst_length=0 → the grant alternates 0,3,0,3 with one word each.
- Reset mid-burst: rst_n low for 1 cycle during a burst from FIFO 1 → fifo_egr_enable=0 in the reset cycle; afterwards mst_valid=0, state IDLE, and the next grant goes to FIFO 0 if it is non-empty.

Source files
------------

// File: rtl/fifo_egress_arbiter.sv
// rtl/fifo_egress_arbiter.sv - round-robin burst drain of N FIFO egress ports onto one valid/ready stream
module fifo_egress_arbiter #(
    parameter int NR_OF_FIFOS_P = 4,
    parameter int DATA_WIDTH_P  = 8,
    parameter int BURST_WIDTH_P = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [BURST_WIDTH_P-1:0]                cr_burst_length,
    input  logic [NR_OF_FIFOS_P-1:0]                fifo_egr_empty,
    input  logic [NR_OF_FIFOS_P*DATA_WIDTH_P-1:0]   fifo_egr_data,
    output logic [NR_OF_FIFOS_P-1:0]                fifo_egr_enable,
    output logic                                    mst_valid,
    input  logic                                    mst_ready,
    output logic [DATA_WIDTH_P-1:0]                 mst_data,
    output logic [$clog2(NR_OF_FIFOS_P)-1:0]        mst_id,
    output logic [NR_OF_FIFOS_P-1:0]                sr_grant
);

    localparam int ID_W = $clog2(NR_OF_FIFOS_P);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [ID_W-1:0]          grant_q, grant_d;
    logic [ID_W-1:0]          last_grant_q, last_grant_d;
    logic [BURST_WIDTH_P-1:0] words_left_q, words_left_d;
    logic                     mst_valid_q, mst_valid_d;
    logic [DATA_WIDTH_P-1:0]  mst_data_q, mst_data_d;
    logic [ID_W-1:0]          mst_id_q, mst_id_d;

    logic                     arb_found;
    logic [ID_W-1:0]          arb_idx;
    logic [BURST_WIDTH_P-1:0] burst_load;
    logic [DATA_WIDTH_P-1:0]  head_data;
    logic                     pop;

    // First non-empty FIFO searching upward from the one after last_grant.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= NR_OF_FIFOS_P; k++) begin
            if (!arb_found &&
                !fifo_egr_empty[ID_W'((int'(last_grant_q) + k) % NR_OF_FIFOS_P)]) begin
                arb_found = 1'b1;
                arb_idx   = ID_W'((int'(last_grant_q) + k) % NR_OF_FIFOS_P);
            end
        end
    end

    assign burst_load = (cr_burst_length == '0) ? BURST_WIDTH_P'(1) : cr_burst_length;
    assign head_data  = fifo_egr_data[grant_q*DATA_WIDTH_P +: DATA_WIDTH_P];
    assign pop        = (state_q == BURST) && !fifo_egr_empty[grant_q] &&
                        (words_left_q != '0) && (!mst_valid_q || mst_ready);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        words_left_d = words_left_q;
        mst_valid_d  = mst_valid_q;
        mst_data_d   = mst_data_q;
        mst_id_d     = mst_id_q;

        // Output stage drains regardless of FSM state; a pop below overrides it.
        if (mst_valid_q && mst_ready) begin
            mst_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d      = BURST;
                    grant_d      = arb_idx;
                    last_grant_d = arb_idx;
                    words_left_d = burst_load;
                end
            end
            BURST: begin
                if (pop) begin
                    mst_data_d   = head_data;
                    mst_id_d     = grant_q;
                    mst_valid_d  = 1'b1;
                    words_left_d = words_left_q - BURST_WIDTH_P'(1);
                    if (words_left_q == BURST_WIDTH_P'(1)) begin
                        state_d = IDLE;
                    end
                end else if (fifo_egr_empty[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NR_OF_FIFOS_P - 1);
            words_left_q <= '0;
            mst_valid_q  <= 1'b0;
            mst_data_q   <= '0;
            mst_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            words_left_q <= words_left_d;
            mst_valid_q  <= mst_valid_d;
            mst_data_q   <= mst_data_d;
            mst_id_q     <= mst_id_d;
        end
    end

    // Pop strobe is gated by rst_n so no word is lost while reset is asserted.
    always_comb begin
        fifo_egr_enable = '0;
        if (pop && rst_n) begin
            fifo_egr_enable[grant_q] = 1'b1;
        end
    end

    always_comb begin
        sr_grant = '0;
        if (state_q == BURST) begin
            sr_grant[grant_q] = 1'b1;
        end
    end

    assign mst_valid = mst_valid_q;
    assign mst_data  = mst_data_q;
    assign mst_id    = mst_id_q;

endmodule

// File: tb/tb_fifo_egress_arbiter.sv
// tb/tb_fifo_egress_arbiter.sv - directed scoreboard bench for fifo_egress_arbiter
module tb_fifo_egress_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [BW-1:0]     cr_burst_length;
    logic [N-1:0]      fifo_egr_empty;
    logic [N*DW-1:0]   fifo_egr_data;
    logic [N-1:0]      fifo_egr_enable;
    logic              mst_valid;
    logic              mst_ready;
    logic [DW-1:0]     mst_data;
    logic [1:0]        mst_id;
    logic [N-1:0]      sr_grant;

    fifo_egress_arbiter #(
        .NR_OF_FIFOS_P (N),
        .DATA_WIDTH_P  (DW),
        .BURST_WIDTH_P (BW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cr_burst_length (cr_burst_length),
        .fifo_egr_empty  (fifo_egr_empty),
        .fifo_egr_data   (fifo_egr_data),
        .fifo_egr_enable (fifo_egr_enable),
        .mst_valid       (mst_valid),
        .mst_ready       (mst_ready),
        .mst_data        (mst_data),
        .mst_id          (mst_id),
        .sr_grant        (sr_grant)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fq [N][$];
    logic [9:0]    sbq [$];
    logic [N-1:0]  grant_seq [$];

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           ready_mode = 0;
    bit           sb_on = 1'b1;
    int           acc_cnt, pop_cnt, grant_starts;
    logic [N-1:0] pend_en = '0;
    logic [N-1:0] prev_grant = '0;
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [1:0]   prev_id = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            fifo_egr_empty[i] = (fq[i].size() == 0);
            fifo_egr_data[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic load(input int f, input logic [DW-1:0] d);
        fq[f].push_back(d);
    endtask

    task automatic expect_word(input int f, input logic [DW-1:0] d);
        sbq.push_back({2'(f), d});
    endtask

    // One clock: apply pops seen at the previous sample, update inputs, sample at negedge.
    task automatic step();
        logic [9:0] exp;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pend_en[i] && fq[i].size() != 0) begin
                void'(fq[i].pop_front());
                pop_cnt++;
            end
        end
        cyc++;
        mst_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        drive();
        @(negedge clk);
        pend_en = fifo_egr_enable;
        chk("en_onehot", 32'($onehot0(fifo_egr_enable)), 32'd1);
        chk("en_while_empty", 32'(fifo_egr_enable & fifo_egr_empty), 32'd0);
        if (sb_on) begin
            if (prev_valid && !prev_ready) begin
                chk("stall_valid", 32'(mst_valid), 32'd1);
                chk("stall_data", 32'(mst_data), 32'(prev_data));
                chk("stall_id", 32'(mst_id), 32'(prev_id));
            end
            if (mst_valid && mst_ready) begin
                acc_cnt++;
                total++;
                assert (sbq.size() != 0) else begin
                    bad++;
                    $error("FAIL sb_extra_word observed=%0h expected=none", {mst_id, mst_data});
                end
                if (sbq.size() != 0) begin
                    exp = sbq.pop_front();
                    chk("sb_word", 32'({mst_id, mst_data}), 32'(exp));
                end
            end
            if (sr_grant != '0 && prev_grant == '0) begin
                grant_starts++;
                grant_seq.push_back(sr_grant);
            end
        end
        prev_grant = sr_grant;
        prev_valid = mst_valid;
        prev_ready = mst_ready;
        prev_data  = mst_data;
        prev_id    = mst_id;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        pend_en    = fifo_egr_enable;
        prev_valid = 1'b0;
        step();
        rst_n = 1'b1;
        prev_valid = 1'b0;
        prev_grant = '0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((sbq.size() != 0 || mst_valid || fq[0].size() != 0 || fq[1].size() != 0 ||
                fq[2].size() != 0 || fq[3].size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_left"}, 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        mst_ready = 1'b1;
        cr_burst_length = 4'd8;
        drive();
        #2;
        chk("en_reset_pre_edge", 32'(fifo_egr_enable), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        chk("rst_valid", 32'(mst_valid), 32'd0);
        chk("rst_data", 32'(mst_data), 32'd0);
        chk("rst_id", 32'(mst_id), 32'd0);
        chk("rst_grant", 32'(sr_grant), 32'd0);
        chk("rst_en", 32'(fifo_egr_enable), 32'd0);

        // Idle with all FIFOs empty
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_en", 32'(fifo_egr_enable), 32'd0);
            chk("idle_valid", 32'(mst_valid), 32'd0);
            chk("idle_grant", 32'(sr_grant), 32'd0);
        end

        // Single source, burst ends early after 3 words
        acc_cnt = 0;
        load(2, 8'hA1); load(2, 8'hB2); load(2, 8'hC3);
        expect_word(2, 8'hA1); expect_word(2, 8'hB2); expect_word(2, 8'hC3);
        drive();
        step();
        chk("ss_c1_grant", 32'(sr_grant), 32'h4);
        chk("ss_c1_en", 32'(fifo_egr_enable), 32'h4);
        chk("ss_c1_valid", 32'(mst_valid), 32'd0);
        step();
        chk("ss_c2_valid", 32'(mst_valid), 32'd1);
        chk("ss_c2_data", 32'(mst_data), 32'hA1);
        chk("ss_c2_id", 32'(mst_id), 32'd2);
        step();
        chk("ss_c3_data", 32'(mst_data), 32'hB2);
        step();
        chk("ss_c4_data", 32'(mst_data), 32'hC3);
        chk("ss_c4_grant", 32'(sr_grant), 32'h4);
        chk("ss_c4_en", 32'(fifo_egr_enable), 32'd0);
        step();
        chk("ss_c5_grant", 32'(sr_grant), 32'd0);
        chk("ss_c5_valid", 32'(mst_valid), 32'd0);
        chk("ss_count", 32'(acc_cnt), 32'd3);
        reset_dut();

        // Round robin, 4 FIFOs x 5 words, burst 2
        cr_burst_length = 4'd2;
        acc_cnt = 0;
        for (int i = 0; i < N; i++)
            for (int w = 0; w < 5; w++) load(i, 8'(i*16 + w));
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < N; i++)
                for (int w = b*2; w < b*2 + 2 && w < 5; w++) expect_word(i, 8'(i*16 + w));
        drive();
        drain("rr", 200);
        chk("rr_count", 32'(acc_cnt), 32'd20);
        reset_dut();

        // Backpressure, FIFO 1 with 12 words, burst 4, ready 1,0,0,...
        cr_burst_length = 4'd4;
        ready_mode = 1;
        acc_cnt = 0; pop_cnt = 0; grant_starts = 0;
        for (int w = 0; w < 12; w++) begin
            load(1, 8'(8'h40 + w));
            expect_word(1, 8'(8'h40 + w));
        end
        drive();
        drain("bp", 400);
        chk("bp_pops", 32'(pop_cnt), 32'd12);
        chk("bp_grants", 32'(grant_starts), 32'd3);
        chk("bp_count", 32'(acc_cnt), 32'd12);
        ready_mode = 0;
        reset_dut();

        // Burst length 0 behaves as 1
        cr_burst_length = 4'd0;
        acc_cnt = 0; grant_starts = 0;
        grant_seq.delete();
        for (int w = 0; w < 3; w++) begin
            load(0, 8'(8'h80 + w));
            load(3, 8'(8'hC0 + w));
            expect_word(0, 8'(8'h80 + w));
            expect_word(3, 8'(8'hC0 + w));
        end
        drive();
        drain("b0", 200);
        chk("b0_grants", 32'(grant_starts), 32'd6);
        chk("b0_count", 32'(acc_cnt), 32'd6);
        for (int k = 0; k < grant_seq.size() && k < 6; k++)
            chk("b0_grant_seq", 32'(grant_seq[k]), (k % 2 == 0) ? 32'h1 : 32'h8);
        reset_dut();

        // Reset in the middle of a burst from FIFO 1
        sb_on = 1'b0;
        cr_burst_length = 4'd4;
        for (int w = 0; w < 6; w++) load(1, 8'(8'h20 + w));
        drive();
        step();
        step();
        chk("rm_en_before", 32'(fifo_egr_enable), 32'h2);
        chk("rm_valid_before", 32'(mst_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rm_en_forced", 32'(fifo_egr_enable), 32'd0);
        pend_en = fifo_egr_enable;
        step();
        rst_n = 1'b1;
        chk("rm_valid_after", 32'(mst_valid), 32'd0);
        chk("rm_grant_after", 32'(sr_grant), 32'd0);
        load(0, 8'h5A);
        drive();
        #1;
        pend_en = fifo_egr_enable;
        step();
        chk("rm_next_grant", 32'(sr_grant), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
